// File: rtl/cnt_sched.sv
// Round-robin owner of a shared saturating event counter.
// Grants bounded increment bursts and gates counter resets to one window value.
module cnt_sched #(
  parameter int WIDTH        = 5,
  parameter int NREQ         = 2,
  parameter int RESET_WINDOW = 15,
  parameter int BURST        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rst_req,
  input  logic             stay,
  output logic [NREQ-1:0]  grant,
  output logic [WIDTH-1:0] counter,
  output logic             error,
  output logic             _rt_check,
  output logic             _rt_event
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             pend_q, pend_d;
  logic             error_q, error_d;

  logic             win;
  logic             inc;
  logic [WIDTH-1:0] cnt_next;
  logic [BW-1:0]    burst_inc;
  logic             release_o;
  logic [PW:0]      pk;
  logic [NREQ-1:0]  own_oh;

  // First set bit of m at or after s, wrapping; MSB flags a hit.
  function automatic logic [PW:0] pick(
    input logic [NREQ-1:0] m,
    input logic [PW-1:0]   s
  );
    logic [PW:0] r;
    int k;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(s) + i) % NREQ;
      if (m[k]) r = {1'b1, PW'(k)};
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    counter_d = counter_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    pend_d    = pend_q;
    error_d   = error_q;
    pk        = '0;
    burst_inc = burst_q;
    release_o = 1'b0;
    own_oh    = NREQ'(1) << owner_q;

    win = pend_q && (counter_q == WIDTH'(RESET_WINDOW)) && !stay;
    inc = (state_q == OWN) && req[owner_q] && !stay;

    if (win)      cnt_next = '0;
    else if (inc) cnt_next = counter_q + 1'b1;
    else          cnt_next = counter_q;

    unique case (state_q)
      IDLE: begin
        pk = pick(req, ptr_q);
        if (pk[PW]) begin
          state_d = OWN;
          owner_d = pk[PW-1:0];
          grant_d = NREQ'(1) << pk[PW-1:0];
          burst_d = '0;
        end
      end
      OWN: begin
        burst_inc = inc ? burst_q + 1'b1 : burst_q;
        burst_d   = burst_inc;
        release_o = !req[owner_q] || (inc && burst_inc == BW'(BURST));
        if (release_o) begin
          ptr_d = PW'((int'(owner_q) + 1) % NREQ);
          pk    = pick(req & ~own_oh, ptr_d);
          if (pk[PW]) begin
            owner_d = pk[PW-1:0];
            grant_d = NREQ'(1) << pk[PW-1:0];
            burst_d = '0;
          end else if (req[owner_q]) begin
            burst_d = '0;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (state_q != ERR) begin
      counter_d = cnt_next;
      pend_d    = (pend_q & ~win) | (|rst_req);
      // Saturation traps at the edge the all-ones value lands.
      if (cnt_next == {WIDTH{1'b1}}) begin
        error_d = 1'b1;
        state_d = ERR;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      counter_q <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      burst_q   <= '0;
      pend_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      counter_q <= counter_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      pend_q    <= pend_d;
      error_q   <= error_d;
    end
  end

  assign grant     = grant_q;
  assign counter   = counter_q;
  assign error     = error_q;
  assign _rt_check = (counter_q == WIDTH'(1));
  assign _rt_event = !_rt_check;

endmodule
